// File: rtl/wf_ram_reader_pkg.sv
// wf_ram_reader_pkg: shared waveform-reader state encodings and constants
package wf_ram_reader_pkg;
  localparam int WF_ADDR_W     = 9;
  localparam int WF_DATA_W     = 16;
  localparam int WF_RAM_LAT    = 1;
  localparam int WF_MIN_PERIOD = WF_RAM_LAT + 2;

  typedef enum logic [2:0] {
    WF_R_IDLE,
    WF_R_FETCH,
    WF_R_WAIT,
    WF_R_HOLD,
    WF_R_DONE
  } wf_r_state_t;

  // FETCH plus RAM_LAT wait clocks plus at least one HOLD clock
  function automatic logic [31:0] wf_min_period(input int ram_lat);
    return 32'(ram_lat + 2);
  endfunction
endpackage

// File: rtl/wf_ram_reader_rate_timer.sv
// wf_rate_timer: per-sample period counter; load sets 1, clear sets 0, else counts up
module wf_rate_timer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic [31:0] i_period,
  output logic [31:0] o_cnt,
  output logic        o_tc
);
  logic [31:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_cnt <= '0;
    else r_cnt <= i_clear ? '0 : i_load ? 32'd1 : r_cnt + 32'd1;

  assign o_cnt = r_cnt;
  assign o_tc  = r_cnt >= i_period;
endmodule

// File: rtl/wf_ram_reader.sv
// wf_ram_reader: plays the waveform table back from RAM, one sample every period clocks
module wf_ram_reader
  import wf_ram_reader_pkg::*;
#(
  parameter int ADDR_W  = WF_ADDR_W,
  parameter int DATA_W  = WF_DATA_W,
  parameter int RAM_LAT = WF_RAM_LAT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wf_start,
  input  logic              i_wf_stop,
  input  logic              i_wf_loop,
  input  logic [31:0]       i_wf_max_cnt,
  input  logic [31:0]       i_wf_period,
  output logic [ADDR_W-1:0] o_wf_ram_addr,
  output logic              o_wf_ram_ce,
  input  logic [DATA_W-1:0] i_wf_ram_dout,
  output logic [DATA_W-1:0] o_wf_data,
  output logic              o_wf_valid,
  output logic [31:0]       o_wf_read_cnt,
  output logic              o_dsp_wf_mode,
  output logic              o_wf_done
);
  localparam logic [31:0] DEPTH    = 32'(2 ** ADDR_W);
  localparam logic [31:0] MIN_PER  = wf_min_period(RAM_LAT);
  localparam logic [31:0] WAIT_END = 32'(RAM_LAT + 1);

  wf_r_state_t       r_state, w_next;
  logic              r_start_d, r_loop, r_valid, r_mode, r_done;
  logic [31:0]       r_max_cnt, r_period, r_read_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [31:0]       w_cnt, w_clamp_cnt, w_clamp_per;
  logic              w_tc, w_start_edge, w_wait_last, w_more;

  assign w_start_edge = i_wf_start & ~r_start_d;
  assign w_clamp_cnt  = (i_wf_max_cnt > DEPTH) ? DEPTH : i_wf_max_cnt;
  assign w_clamp_per  = (i_wf_period < MIN_PER) ? MIN_PER : i_wf_period;
  // the timer holds 1 on the FETCH clock, so the last WAIT clock sits at RAM_LAT+1
  assign w_wait_last  = (r_state == WF_R_WAIT) && (w_cnt == WAIT_END);
  assign w_more       = r_read_cnt < r_max_cnt;

  wf_rate_timer u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_next == WF_R_IDLE),
    .i_load   (w_next == WF_R_FETCH),
    .i_period (r_period),
    .o_cnt    (w_cnt),
    .o_tc     (w_tc)
  );

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_state <= WF_R_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    if (i_wf_stop) w_next = WF_R_IDLE;
    else
      unique case (r_state)
        WF_R_IDLE:  w_next = w_start_edge ? ((w_clamp_cnt == 32'd0) ? WF_R_DONE : WF_R_FETCH) : WF_R_IDLE;
        WF_R_FETCH: w_next = WF_R_WAIT;
        WF_R_WAIT:  w_next = w_wait_last ? WF_R_HOLD : WF_R_WAIT;
        WF_R_HOLD:  w_next = w_tc ? ((w_more || r_loop) ? WF_R_FETCH : WF_R_DONE) : WF_R_HOLD;
        WF_R_DONE:  w_next = WF_R_IDLE;
        default:    w_next = WF_R_IDLE;
      endcase
  end

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_start_d  <= 1'b0;
      r_loop     <= 1'b0;
      r_max_cnt  <= '0;
      r_period   <= '0;
      r_read_cnt <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_mode     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_start_d <= i_wf_start;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      if (i_wf_stop) r_mode <= 1'b0;
      else
        unique case (r_state)
          WF_R_IDLE:
            if (w_start_edge) begin
              r_loop     <= i_wf_loop;
              r_max_cnt  <= w_clamp_cnt;
              r_period   <= w_clamp_per;
              r_read_cnt <= '0;
              r_addr     <= '0;
              r_mode     <= 1'b1;
            end
          WF_R_WAIT:
            if (w_wait_last) begin
              r_data     <= i_wf_ram_dout;
              r_valid    <= 1'b1;
              r_read_cnt <= r_read_cnt + 32'd1;
            end
          WF_R_HOLD:
            if (w_tc) begin
              if (w_more) r_addr <= r_addr + 1'b1;
              else if (r_loop) begin
                r_addr     <= '0;
                r_read_cnt <= '0;
              end
            end
          WF_R_DONE: begin
            r_done <= 1'b1;
            r_mode <= 1'b0;
          end
          default: ;
        endcase
    end

  assign o_wf_ram_addr = r_addr;
  assign o_wf_ram_ce   = (r_state == WF_R_FETCH) && !i_wf_stop;
  assign o_wf_data     = r_data;
  assign o_wf_valid    = r_valid;
  assign o_wf_read_cnt = r_read_cnt;
  assign o_dsp_wf_mode = r_mode;
  assign o_wf_done     = r_done;
endmodule

// File: tb/tb_wf_ram_reader.sv
// tb_wf_ram_reader: directed table plus hand sequences for the waveform reader
module tb_wf_ram_reader;
  localparam int AW = 9;
  localparam int DW = 16;

  logic          clk = 0, rst = 1;
  logic          start = 0, stop = 0, wf_loop = 0;
  logic [31:0]   max_cnt = 0, period = 0;
  logic [AW-1:0] o_addr;
  logic          o_ce, o_valid, o_mode, o_done;
  logic [DW-1:0] ram_dout = 0, o_data;
  logic [31:0]   o_cnt;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int cyc = 0;
  int n_tests = 0, n_fail = 0;

  int s_data[$], s_cnt[$], s_cyc[$];
  int ce_cnt, done_cnt, done_cyc, last_ce_addr;

  wf_ram_reader #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_wf_start(start), .i_wf_stop(stop), .i_wf_loop(wf_loop),
    .i_wf_max_cnt(max_cnt), .i_wf_period(period), .o_wf_ram_addr(o_addr), .o_wf_ram_ce(o_ce),
    .i_wf_ram_dout(ram_dout), .o_wf_data(o_data), .o_wf_valid(o_valid), .o_wf_read_cnt(o_cnt),
    .o_dsp_wf_mode(o_mode), .o_wf_done(o_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (o_ce) ram_dout <= mem[o_addr];

  always @(negedge clk) begin
    if (o_valid) begin
      s_data.push_back(int'(o_data));
      s_cnt.push_back(int'(o_cnt));
      s_cyc.push_back(cyc);
    end
    if (o_ce) begin
      ce_cnt++;
      last_ce_addr = int'(o_addr);
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  typedef struct {
    bit lp;
    int mc, per;
    int exp_n, exp_sp, exp_last, exp_done;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    s_data.delete(); s_cnt.delete(); s_cyc.delete();
    ce_cnt = 0; done_cnt = 0; done_cyc = -1; last_ce_addr = -1;
  endtask

  task automatic launch(input bit lp, input int mc, input int per, output int t0);
    clear_mon();
    @(posedge clk); #1;
    wf_loop = lp; max_cnt = mc; period = per; start = 1; t0 = cyc;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk); #1; n++;
    end
    chk("done_seen", done_cnt != 0, 1);
  endtask

  task automatic idle(input int n);
    start = 0; stop = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int seq_bad(input int n, input int sp, input int wrap);
    int bad = 0;
    for (int j = 0; j < n; j++) begin
      if (s_data[j] != int'(mem[j % wrap])) bad++;
      if (j > 0 && s_cyc[j] - s_cyc[j-1] != sp) bad++;
    end
    return bad;
  endfunction

  initial begin
    int t0, n;
    int first[$];
    for (int i = 0; i < (1<<AW); i++) mem[i] = 16'h5A00 ^ DW'(i * 37);
    vecs[0] = '{0, 4,    5, 4,   5, 3,   22};
    vecs[1] = '{0, 0,    5, 0,   0, -1,  2};
    vecs[2] = '{0, 1000, 1, 512, 3, 511, 1538};
    vecs[3] = '{0, 3,    2, 3,   3, 2,   11};
    vecs[4] = '{0, 2,    7, 2,   7, 1,   16};
    vecs[5] = '{0, 1,    0, 1,   3, 0,   5};
    clear_mon();

    repeat (2) @(negedge clk);
    chk("reset_outputs", {o_addr, o_ce, o_data, o_valid, o_cnt, o_mode, o_done}, 0);
    @(posedge clk); #1 rst = 0;
    idle(2);

    foreach (vecs[v]) begin
      launch(vecs[v].lp, vecs[v].mc, vecs[v].per, t0);
      wait_done(3000);
      repeat (3) @(negedge clk);
      #1;
      chk($sformatf("v%0d_strobes", v), s_data.size(), vecs[v].exp_n);
      chk($sformatf("v%0d_ce_pulses", v), ce_cnt, vecs[v].exp_n);
      chk($sformatf("v%0d_last_addr", v), last_ce_addr, vecs[v].exp_last);
      chk($sformatf("v%0d_read_cnt", v), o_cnt, vecs[v].exp_n);
      chk($sformatf("v%0d_done_count", v), done_cnt, 1);
      chk($sformatf("v%0d_done_cycle", v), done_cyc - t0, vecs[v].exp_done);
      chk($sformatf("v%0d_mode_low", v), o_mode, 0);
      if (s_data.size() == vecs[v].exp_n && vecs[v].exp_n > 0) begin
        chk($sformatf("v%0d_first_latency", v), s_cyc[0] - t0, 3);
        chk($sformatf("v%0d_seq_errors", v), seq_bad(vecs[v].exp_n, vecs[v].exp_sp, 1 << AW), 0);
        chk($sformatf("v%0d_last_data", v), o_data, mem[vecs[v].exp_last]);
      end
      idle(3);
    end

    // loop run stopped after seven strobes
    launch(1, 3, 4, t0);
    n = 0;
    while (s_data.size() < 7 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk("loop_reached_7", s_data.size(), 7);
    chk("loop_mode_high", o_mode, 1);
    stop = 1;
    @(posedge clk); #1 stop = 0;
    repeat (12) @(negedge clk);
    #1;
    chk("loop_strobes_after_stop", s_data.size(), 7);
    chk("loop_seq_errors", seq_bad(7, 4, 3), 0);
    for (int j = 0; j < 7; j++) chk($sformatf("loop_cnt_%0d", j), s_cnt[j], j % 3 + 1);
    chk("loop_no_done", done_cnt, 0);
    chk("loop_mode_low", o_mode, 0);
    chk("loop_data_held", o_data, mem[0]);
    chk("loop_cnt_held", o_cnt, 1);
    idle(3);

    // start held high through DONE, then re-armed
    launch(0, 2, 3, t0);
    wait_done(200);
    first = s_data;
    repeat (20) @(negedge clk);
    #1;
    chk("held_no_rerun_ce", ce_cnt, 2);
    chk("held_done_once", done_cnt, 1);
    idle(2);
    launch(0, 2, 3, t0);
    wait_done(200);
    chk("rearm_strobes", s_data.size(), 2);
    if (s_data.size() == 2 && first.size() == 2) begin
      chk("rearm_same_d0", s_data[0], first[0]);
      chk("rearm_same_d1", s_data[1], first[1]);
      chk("rearm_spacing", s_cyc[1] - s_cyc[0], 3);
    end
    idle(3);

    // simultaneous start and stop in IDLE: stop wins and consumes the edge
    clear_mon();
    @(posedge clk); #1;
    max_cnt = 4; period = 5; wf_loop = 0; start = 1; stop = 1;
    @(posedge clk); #1 stop = 0;
    repeat (10) @(negedge clk);
    #1;
    chk("start_stop_no_ce", ce_cnt, 0);
    chk("start_stop_mode", o_mode, 0);
    idle(2);

    // reset during WAIT
    launch(0, 4, 5, t0);
    n = 0;
    while (ce_cnt == 0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("rst_ce_seen", ce_cnt, 1);
    @(posedge clk); #1;
    rst = 1; start = 0;
    #1;
    chk("rst_outputs_zero", {o_addr, o_ce, o_data, o_valid, o_cnt, o_mode, o_done}, 0);
    @(negedge clk);
    chk("rst_data_zero", o_data, 0);
    @(posedge clk); #1 rst = 0;
    idle(2);
    launch(0, 4, 5, t0);
    wait_done(200);
    chk("post_rst_strobes", s_data.size(), 4);
    if (s_data.size() == 4) begin
      chk("post_rst_latency", s_cyc[0] - t0, 3);
      chk("post_rst_seq_errors", seq_bad(4, 5, 1 << AW), 0);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
